// File: rtl/i2s_rx_if.sv
// i2s_rx_if: output handshake bundle of the I2S receiver.
//   out_left  - left sample of the last completed frame (WIDTH bits)
//   out_right - right sample of the last completed frame (WIDTH bits)
//   out_valid - out_left/out_right hold an unconsumed frame
//   out_ready - consumer accepts the frame when out_valid && out_ready
// master: the receiver (frame source); slave: the consumer.
`timescale 1ns/1ps
interface i2s_rx_if #(
    parameter int unsigned WIDTH = 24
);
    logic [WIDTH-1:0] out_left;
    logic [WIDTH-1:0] out_right;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_left,
        output out_right,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_left,
        input  out_right,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial audio receiver with a valid/ready frame output.
//   clk       - system clock, all state on its rising edge
//   rst       - asynchronous active-low reset
//   sck       - codec bit clock (asynchronous to clk)
//   lrck      - word select, low = left, high = right (asynchronous)
//   sdin      - serial data, MSB first, sampled on sck rise
//   out_if    - frame output: out_left/out_right/out_valid/out_ready
//   overrun   - sticky: a completed frame was dropped
//   short_err - sticky: a slot ended with fewer than WIDTH bits
//   err_clr   - synchronous clear of both sticky flags
// sck high and low phases must each last at least 3 clk periods.
`timescale 1ns/1ps
module i2s_rx #(
    parameter int unsigned WIDTH = 24
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      sck,
    input  logic      lrck,
    input  logic      sdin,
    i2s_rx_if.master  out_if,
    output logic      overrun,
    output logic      short_err,
    input  logic      err_clr
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {SYNC, DELAY, SHIFT, HOLD} state_t;

    // Matched two-flop synchronizers plus one history flop for edge detect.
    logic sck_s1_q, sck_s2_q, sck_p_q;
    logic lrck_s1_q, lrck_s2_q, lrck_p_q;
    logic sdin_s1_q, sdin_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_p_q   <= 1'b0;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
            lrck_p_q  <= 1'b0;
            sdin_s1_q <= 1'b0;
            sdin_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= sck;
            sck_s2_q  <= sck_s1_q;
            sck_p_q   <= sck_s2_q;
            lrck_s1_q <= lrck;
            lrck_s2_q <= lrck_s1_q;
            lrck_p_q  <= lrck_s2_q;
            sdin_s1_q <= sdin;
            sdin_s2_q <= sdin_s1_q;
        end
    end

    logic sck_rise, lrck_fall, lrck_edge;
    assign sck_rise  = sck_s2_q & ~sck_p_q;
    assign lrck_fall = ~lrck_s2_q & lrck_p_q;
    assign lrck_edge = lrck_s2_q ^ lrck_p_q;

    state_t           state_q, state_d;
    logic             chan_q, chan_d;     // 0 = left slot, 1 = right slot
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             short_q, short_d;

    logic             frame_load;
    logic             short_set;
    logic             ovr_set;
    logic [WIDTH-1:0] msb_mask;

    // Bits land at position WIDTH-1-cnt of a register cleared at slot start,
    // so a short slot is already left-aligned with zero-filled LSBs.
    assign msb_mask = {1'b1, {(WIDTH-1){1'b0}}} >> cnt_q;

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        hold_d     = hold_q;
        frame_load = 1'b0;
        short_set  = 1'b0;
        case (state_q)
            SYNC: begin
                if (lrck_fall) begin
                    chan_d  = 1'b0;
                    cnt_d   = '0;
                    shreg_d = '0;
                    // A coincident sck rise is consumed as the delay bit.
                    state_d = sck_rise ? SHIFT : DELAY;
                end
            end
            default: begin
                if (lrck_edge) begin
                    short_set = (cnt_q != CW'(WIDTH));
                    if (chan_q) begin
                        frame_load = 1'b1;
                    end else begin
                        hold_d = shreg_q;
                    end
                    chan_d  = lrck_s2_q;
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = sck_rise ? SHIFT : DELAY;
                end else if (sck_rise) begin
                    if (state_q == DELAY) begin
                        state_d = SHIFT;
                    end else if (state_q == SHIFT) begin
                        if (sdin_s2_q) begin
                            shreg_d = shreg_q | msb_mask;
                        end
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
        endcase
    end

    // Frame output handshake and sticky flags.
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        ovr_set = 1'b0;
        if (frame_load) begin
            if (valid_q && !out_if.out_ready) begin
                ovr_set = 1'b1;
            end else begin
                left_d  = hold_q;
                right_d = shreg_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end
        // A set event in the same cycle as err_clr wins.
        ovr_d   = (err_clr ? 1'b0 : ovr_q) | ovr_set;
        short_d = (err_clr ? 1'b0 : short_q) | short_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SYNC;
            chan_q  <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
            hold_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            hold_q  <= hold_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            short_q <= short_d;
        end
    end

    assign out_if.out_left  = left_q;
    assign out_if.out_right = right_q;
    assign out_if.out_valid = valid_q;
    assign overrun          = ovr_q;
    assign short_err        = short_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx (WIDTH=24, sck = clk/8).
// Frames are streamed continuously; a frame becomes visible at the lrck
// fall that opens the following left slot, so each vector is checked from
// snapshots taken inside that slot.
`timescale 1ns/1ps
module tb_i2s_rx;

    logic clk = 1'b0;
    logic rst;
    logic sck;
    logic lrck;
    logic sdin;
    logic overrun;
    logic short_err;
    logic err_clr;

    i2s_rx_if #(.WIDTH(24)) bus ();

    i2s_rx #(.WIDTH(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .lrck      (lrck),
        .sdin      (sdin),
        .out_if    (bus),
        .overrun   (overrun),
        .short_err (short_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Count of negedge samples with out_valid high.
    int valid_cnt = 0;
    always @(negedge clk) if (bus.out_valid) valid_cnt <= valid_cnt + 1;

    // Snapshots taken 3 and 4 clk after an lrck change (load cycle = 3).
    logic        s3_valid, s4_valid, s3_ovr, s3_short;
    logic [23:0] s3_left, s3_right;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          n;
        int          pad;
        logic [23:0] el;
        logic [23:0] er;
        logic        es;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One slot: delay bit, nbits data bits (MSB of data[nbits-1:0] first),
    // then npad zero bits. lrck changes with the first sck fall.
    task automatic send_slot(input logic lr, input logic [31:0] data, input int nbits,
                             input int npad, input bit ready_pulse, input bit clr);
        for (int b = 0; b < 1 + nbits + npad; b++) begin
            sck = 1'b0;
            if (b == 0) lrck = lr;
            sdin = (b >= 1 && b <= nbits) ? data[nbits - b] : 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (b == 0) begin
                    if (k == 1 && ready_pulse) bus.out_ready = 1'b1;
                    if (k == 2) begin
                        if (ready_pulse) bus.out_ready = 1'b0;
                        s3_valid = bus.out_valid;
                        s3_left  = bus.out_left;
                        s3_right = bus.out_right;
                        s3_ovr   = overrun;
                        s3_short = short_err;
                    end
                    if (k == 3) s4_valid = bus.out_valid;
                end
            end
            sck = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (b == 0 && k == 0 && clr) err_clr = 1'b1;
                if (b == 0 && k == 1) err_clr = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [23:0] el,
                               input logic [23:0] er, input logic es);
        check({tag, "_left"},      {8'h0, s3_left},  {8'h0, el});
        check({tag, "_right"},     {8'h0, s3_right}, {8'h0, er});
        check({tag, "_valid"},     {31'h0, s3_valid}, 32'd1);
        check({tag, "_valid_end"}, {31'h0, s4_valid}, 32'd0);
        check({tag, "_short"},     {31'h0, s3_short}, {31'h0, es});
        check({tag, "_overrun"},   {31'h0, s3_ovr},   32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;

        vecs[0] = '{32'h00A5C3F0, 32'h000F1E2D, 24, 7, 24'hA5C3F0, 24'h0F1E2D, 1'b0};
        vecs[1] = '{32'h0000BEEF, 32'h00001234, 16, 0, 24'hBEEF00, 24'h123400, 1'b1};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 32, 0, 24'h123456, 24'h9ABCDE, 1'b0};
        vecs[3] = '{32'h00FFFFFF, 32'h00000001, 24, 2, 24'hFFFFFF, 24'h000001, 1'b0};
        vecs[4] = '{32'h0000005A, 32'h0000003C, 0,  0, 24'h000000, 24'h000000, 1'b1};
        vecs[5] = '{32'h00800001, 32'h007FFFFE, 24, 0, 24'h800001, 24'h7FFFFE, 1'b0};

        rst = 1'b0;
        sck = 1'b0;
        lrck = 1'b1;
        sdin = 1'b0;
        err_clr = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_left",    {8'h0, bus.out_left},    32'h0);
        check("rst_right",   {8'h0, bus.out_right},   32'h0);
        check("rst_valid",   {31'h0, bus.out_valid},  32'h0);
        check("rst_overrun", {31'h0, overrun},        32'h0);
        check("rst_short",   {31'h0, short_err},      32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Table of frames, streamed back to back with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            send_slot(1'b0, vecs[i].l, vecs[i].n, vecs[i].pad, 1'b0, 1'b1);
            if (i > 0) check_frame($sformatf("v%0d", i - 1), vecs[i-1].el, vecs[i-1].er, vecs[i-1].es);
            send_slot(1'b1, vecs[i].r, vecs[i].n, vecs[i].pad, 1'b0, 1'b0);
        end
        send_slot(1'b0, 32'hA5C3F0, 24, 7, 1'b0, 1'b1);
        check_frame("v5", vecs[5].el, vecs[5].er, vecs[5].es);

        // Backpressure: first frame held, second dropped, overrun sticky.
        send_slot(1'b1, 32'h0F1E2D, 24, 7, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        send_slot(1'b0, 32'h333333, 24, 7, 1'b0, 1'b0);
        check("held_valid",     {31'h0, s3_valid}, 32'd1);
        check("held_left",      {8'h0, s3_left},   32'hA5C3F0);
        check("held_valid_end", {31'h0, s4_valid}, 32'd1);
        send_slot(1'b1, 32'h222222, 24, 7, 1'b0, 1'b0);
        send_slot(1'b0, 32'h333333, 24, 7, 1'b0, 1'b0);
        check("drop_overrun", {31'h0, s3_ovr},   32'd1);
        check("drop_left",    {8'h0, s3_left},   32'hA5C3F0);
        check("drop_right",   {8'h0, s3_right},  32'h0F1E2D);
        check("drop_valid",   {31'h0, s3_valid}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("clr_overrun", {31'h0, overrun},       32'd0);
        check("clr_valid",   {31'h0, bus.out_valid}, 32'd1);

        // out_ready rises exactly in the load cycle of the next frame.
        send_slot(1'b1, 32'h444444, 24, 7, 1'b0, 1'b0);
        send_slot(1'b0, 32'h555555, 24, 7, 1'b1, 1'b0);
        check("coinc_valid",     {31'h0, s3_valid}, 32'd1);
        check("coinc_left",      {8'h0, s3_left},   32'h333333);
        check("coinc_right",     {8'h0, s3_right},  32'h444444);
        check("coinc_overrun",   {31'h0, s3_ovr},   32'd0);
        check("coinc_valid_end", {31'h0, s4_valid}, 32'd1);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("drain_valid", {31'h0, bus.out_valid}, 32'd0);

        // Reset in the middle of a right slot's SHIFT phase.
        send_slot(1'b1, 32'h000ABC, 12, 0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_left",    {8'h0, bus.out_left},   32'h0);
        check("midrst_right",   {8'h0, bus.out_right},  32'h0);
        check("midrst_valid",   {31'h0, bus.out_valid}, 32'h0);
        check("midrst_overrun", {31'h0, overrun},       32'h0);
        check("midrst_short",   {31'h0, short_err},     32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        base = valid_cnt;
        // Remainder of the right slot, lrck still high: must be ignored.
        send_slot(1'b1, 32'h0, 0, 8, 1'b0, 1'b0);
        send_slot(1'b0, 32'hC0FFEE, 24, 7, 1'b0, 1'b0);
        send_slot(1'b1, 32'h123456, 24, 7, 1'b0, 1'b0);
        check("no_early_valid", valid_cnt - base, 32'd0);
        send_slot(1'b0, 32'h0, 24, 7, 1'b0, 1'b0);
        check_frame("post_rst", 24'hC0FFEE, 24'h123456, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
